pdm_mic_capture: RTL and testbench
==================================

Name: pdm_mic_capture

Overview:
- Audio input path; the counterpart of the PWM audio output driven from memory-mapped address 4098.
- Drives the on-board PDM microphone clock and samples its 1-bit PDM stream.
- Decimates the stream to 10-bit samples by counting ones over a fixed window, then buffers samples in a small FIFO.
- The processor pops samples through a memory-mapped read at address 4099. Samples use the same 10-bit scale as the PWM duty cycle, so they can be played back directly.

Parameters:
- CLK_DIV, 8: system-clock cycles per mic_clk half-period. At 50 MHz this gives a 3.125 MHz mic clock.
- WINDOW, 1023: PDM bits per output sample. Must be no greater than 2^SAMPLE_W - 1.
- SAMPLE_W, 10: sample width in bits.
- DEPTH, 16: FIFO entries. Power of two, 2 or more.

Ports:
- clock, in, 1: system clock (50 MHz).
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: capture enable.
- mic_data, in, 1: PDM data from the microphone. Asynchronous to clock.
- mic_clk, out, 1: PDM clock to the microphone.
- mic_lrsel, out, 1: channel select. Tied to 0.
- rd_en, in, 1: one-cycle pop strobe. The wrapper asserts it on a load from address 4099.
- clear_ovf, in, 1: clears the sticky overflow flag.
- rd_data, out, 32: status and head-of-FIFO view (layout below).
- fifo_count, out, log2(DEPTH)+1: number of samples held.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - mic_clk=0, divider=0, bit counter=0, ones accumulator=0.
  - Both synchronizer flops cleared.
  - FIFO empty: read pointer=0, write pointer=0, fifo_count=0.
  - overflow=0, rd_data=0.
- Reset release: the first window starts from bit 0.
- Clock divider:
  - While enable=1, the divider counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and mic_clk toggles.
  - mic_clk period = 2*CLK_DIV clocks, registered output, 50% duty.
- enable=0:
  - mic_clk held 0; divider, bit counter and accumulator cleared.
  - FIFO contents and overflow are retained; pops are still serviced.
- Input sync: mic_data passes through a 2-flop synchronizer giving mic_s.
- Bit sampling:
  - bit_tick is asserted in the cycle in which mic_clk toggles from 1 to 0.
  - On bit_tick, mic_s is taken as the current PDM bit.
- Decimation, on each bit_tick:
  - If bit counter < WINDOW-1: ones += bit; bit counter += 1.
  - If bit counter = WINDOW-1: sample = ones + bit; push is requested next cycle; ones=0; bit counter=0.
  - Output range is 0..WINDOW. No saturation is needed.
- FIFO: synchronous, circular, pointers wrap modulo DEPTH.
  - Push while not full: store, write pointer+1.
  - Push while full and no pop in the same cycle: sample dropped, overflow=1 (sticky).
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: pop ignored, push stored, count=1.
  - rd_en while empty: no effect; pointers unchanged.
- rd_data, combinational from registered state:
  - Bit 31: valid (fifo_count != 0).
  - Bit 30: overflow.
  - Bits 29:SAMPLE_W: 0.
  - Bits SAMPLE_W-1:0: head sample, or 0 when empty.
  - The value updates in the cycle after a pop.
- Overflow clear:
  - clear_ovf=1 clears overflow.
  - If an overflow event occurs in the same cycle, set wins and overflow=1.

Decomposition:
- Shared package (audio_pkg):
  - SAMPLE_W.
  - Address constants: IO_SW=4096, IO_LED=4097, IO_AUDIO_OUT=4098, IO_AUDIO_IN=4099.
  - rd_data bit positions: VALID_BIT=31, OVF_BIT=30.
- One sub-module, sample_fifo, parameterised by WIDTH and DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
- Divider, synchronizer and decimator stay in the top module.

Test Plan (CLK_DIV=2, WINDOW=7, DEPTH=4 unless stated):
1. enable=1, mic_data=1 constant -> mic_clk period 4 clocks; first sample 7; rd_data=0x80000007; fifo_count=1.
2. mic_data=0 constant, one window -> rd_data=0x80000000. Pulse rd_en once -> rd_data=0x00000000, fifo_count=0.
3. mic_data changed on each bit_tick, pattern 1,0,1,0,1,0,1 -> sample 4. Next window with pattern 0,1,0,1,0,1,0 -> sample 3. FIFO order is 4 then 3.
4. mic_data=1, no reads for 5 windows -> fifo_count=4, rd_data=0xC0000007. Pulse clear_ovf -> bit 30=0. Pop 4 times -> values 7,7,7,7, then valid=0.
5. FIFO full; rd_en pulsed in the exact cycle of the 5th push -> no overflow, fifo_count stays 4.
6. reset low for 3 clocks mid-window (bit counter=3) -> mic_clk=0, fifo_count=0, rd_data=0 immediately. After release with mic_data=1 -> first sample 7, from a full window.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the audio I/O blocks: sample width, memory-mapped
// addresses and the status-word layout returned by the capture path.
package audio_pkg;

    localparam int SAMPLE_W = 10;

    localparam int IO_SW        = 4096;
    localparam int IO_LED       = 4097;
    localparam int IO_AUDIO_OUT = 4098;
    localparam int IO_AUDIO_IN  = 4099;

    localparam int VALID_BIT = 31;
    localparam int OVF_BIT   = 30;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer with occupancy count; a pop on an empty buffer is
// ignored and a push on a full buffer is only accepted alongside a pop.
module sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when a pop frees the head slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: generates mic_clk, samples the 1-bit stream on each
// falling mic_clk, decimates by counting ones per window and buffers the samples.
module pdm_mic_capture #(
    parameter int CLK_DIV  = 8,
    parameter int WINDOW   = 1023,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int DEPTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mic_data,
    output logic                     mic_clk,
    output logic                     mic_lrsel,
    input  logic                     rd_en,
    input  logic                     clear_ovf,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]    div_cnt;
    logic                div_wrap;
    logic                bit_tick;
    logic                sync_ff;
    logic                mic_s;
    logic [SAMPLE_W-1:0] bit_cnt;
    logic [SAMPLE_W-1:0] ones;
    logic [SAMPLE_W-1:0] sample;
    logic                push_req;
    logic                overflow;
    logic                ovf_event;
    logic [SAMPLE_W-1:0] head;
    logic                fifo_full;
    logic                fifo_empty;

    assign mic_lrsel = 1'b0;
    assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
    // The toggle about to happen takes mic_clk from 1 to 0: the mic has settled its bit.
    assign bit_tick  = enable && div_wrap && mic_clk;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // NOTE: non-blocking assignments keep these as two distinct flops; blocking would collapse the chain into one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff <= 1'b0;
            mic_s   <= 1'b0;
        end else begin
            sync_ff <= mic_data;
            mic_s   <= sync_ff;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            ones     <= '0;
            sample   <= '0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (!enable) begin
                bit_cnt <= '0;
                ones    <= '0;
            end else if (bit_tick) begin
                if (bit_cnt == SAMPLE_W'(WINDOW - 1)) begin
                    sample   <= ones + SAMPLE_W'(mic_s);
                    push_req <= 1'b1;
                    ones     <= '0;
                    bit_cnt  <= '0;
                end else begin
                    ones    <= ones + SAMPLE_W'(mic_s);
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (rd_en),
        .din   (sample),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A sample is lost only when the buffer is full and nothing is popped alongside it.
    assign ovf_event = push_req && fifo_full && !rd_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // NOTE: rd_data gets a full default first so no path through this block leaves it unassigned (no latch).
    always_comb begin
        rd_data                      = '0;
        rd_data[audio_pkg::VALID_BIT] = !fifo_empty;
        rd_data[audio_pkg::OVF_BIT]   = overflow;
        if (!fifo_empty) begin
            rd_data[SAMPLE_W-1:0] = head;
        end
    end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed plus randomized bench for pdm_mic_capture; expected samples are
// popcounts of the driven PDM windows, tracked in a queue-based FIFO model.
module tb_pdm_mic_capture;

    localparam int CLK_DIV  = 2;
    localparam int WINDOW   = 7;
    localparam int SAMPLE_W = 10;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             mic_data;
    logic             mic_clk;
    logic             mic_lrsel;
    logic             rd_en;
    logic             clear_ovf;
    logic [31:0]      rd_data;
    logic [CNT_W-1:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int q[$];
    bit m_ovf;
    int period;

    always #5 clock = ~clock;

    pdm_mic_capture #(
        .CLK_DIV  (CLK_DIV),
        .WINDOW   (WINDOW),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mic_data   (mic_data),
        .mic_clk    (mic_clk),
        .mic_lrsel  (mic_lrsel),
        .rd_en      (rd_en),
        .clear_ovf  (clear_ovf),
        .rd_data    (rd_data),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        r = '0;
        if (q.size() != 0) begin
            r[31]           = 1'b1;
            r[SAMPLE_W-1:0] = SAMPLE_W'(q[0]);
        end
        r[30] = m_ovf;
        return r;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_rd"}, rd_data, exp_rd());
        check({tag, "_cnt"}, 32'(fifo_count), 32'(q.size()));
    endtask

    task automatic wait_fall(output int cyc);
        logic prev;
        prev = mic_clk;
        cyc  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            cyc++;
            if (prev && !mic_clk) return;
            prev = mic_clk;
        end
        n_tests++;
        n_fail++;
        $error("FAIL mic_clk_fall: observed no falling edge, expected one within 64 cycles");
    endtask

    task automatic model_push(input int s, input bit pop, input bit clr);
        if (pop && q.size() != 0) void'(q.pop_front());
        if (clr) m_ovf = 1'b0;
        if (q.size() < DEPTH) q.push_back(s);
        else m_ovf = 1'b1;
    endtask

    // Drives one window of PDM bits (bits[0] first); nxt is presented right after
    // the last bit so the following window's first bit has time to synchronize.
    task automatic run_window(input logic [6:0] bits, input logic nxt, input bit pop, input bit clr);
        int         cyc;
        logic [7:0] ext;
        ext      = {nxt, bits};
        mic_data = bits[0];
        for (int i = 0; i < WINDOW; i++) begin
            wait_fall(cyc);
            if (i == 1) period = cyc;
            mic_data = ext[i+1];
        end
        rd_en     = pop;
        clear_ovf = clr;
        @(negedge clock);
        rd_en     = 1'b0;
        clear_ovf = 1'b0;
        model_push($countones(bits), pop, clr);
    endtask

    task automatic pop_once(input string tag);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state(tag);
    endtask

    task automatic clear_once(input string tag);
        clear_ovf = 1'b1;
        @(negedge clock);
        clear_ovf = 1'b0;
        m_ovf = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] cur;
        logic [6:0] nxtb;
        int         cyc;
        bit         pp;

        reset = 1'b0; enable = 1'b0; mic_data = 1'b0; rd_en = 1'b0; clear_ovf = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clock);
        check_state("reset");
        check("reset_mic_clk", 32'(mic_clk), 32'd0);
        check("mic_lrsel", 32'(mic_lrsel), 32'd0);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        check("disabled_mic_clk", 32'(mic_clk), 32'd0);

        // Constant ones: full-scale first sample and the mic_clk period.
        enable = 1'b1;
        run_window(7'h7F, 1'b0, 1'b0, 1'b0);
        check("t1_period", 32'(period), 32'd4);
        check("t1_rd_data", rd_data, 32'h8000_0007);
        check("t1_count", 32'(fifo_count), 32'd1);
        check_state("t1");
        pop_once("t1_pop");

        // Constant zeros, then pops including one on an empty buffer.
        run_window(7'h00, 1'b0, 1'b0, 1'b0);
        check("t2_rd_data", rd_data, 32'h8000_0000);
        enable = 1'b0;
        pop_once("t2_pop");
        check("t2_empty", rd_data, 32'h0000_0000);
        pop_once("t2_empty_pop");

        // Alternating patterns give 4 then 3, popped in order.
        enable = 1'b1;
        run_window(7'b1010101, 1'b0, 1'b0, 1'b0);
        check_state("t3_a");
        run_window(7'b0101010, 1'b1, 1'b0, 1'b0);
        check_state("t3_b");
        enable = 1'b0;
        check("t3_head", rd_data, 32'h8000_0004);
        pop_once("t3_pop1");
        check("t3_second", rd_data, 32'h8000_0003);
        pop_once("t3_pop2");

        // Five windows without reads: full and sticky overflow.
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_window(7'h7F, 1'b1, 1'b0, 1'b0);
            check_state("t4_fill");
        end
        check("t4_full", rd_data, 32'hC000_0007);
        check("t4_count", 32'(fifo_count), 32'd4);
        enable = 1'b0;
        clear_once("t4_clr");
        check("t4_cleared", rd_data, 32'h8000_0007);
        for (int k = 0; k < 4; k++) pop_once("t4_drain");
        check("t4_drained", rd_data, 32'h0000_0000);

        // Overflow coinciding with clear_ovf: the set wins.
        enable = 1'b1;
        for (int k = 0; k < 4; k++) run_window(7'h7F, 1'b1, 1'b0, 1'b0);
        run_window(7'h7F, 1'b1, 1'b0, 1'b1);
        check("t4b_set_wins", rd_data, 32'hC000_0007);
        clear_once("t4b_clr");

        // Pop in the exact cycle of a push into a full buffer.
        run_window(7'h7F, 1'b1, 1'b1, 1'b0);
        check("t5_rd_data", rd_data, 32'h8000_0007);
        check("t5_count", 32'(fifo_count), 32'd4);

        // Randomized windows with random pops, against the model.
        nxtb = 7'($urandom);
        for (int r = 0; r < 12; r++) begin
            cur  = nxtb;
            nxtb = 7'($urandom);
            pp   = ($urandom_range(0, 3) == 0);
            run_window(cur, nxtb[0], pp, 1'b0);
            check_state("rand_push");
            if (r < 11 && $urandom_range(0, 1) == 1) pop_once("rand_pop");
        end

        // Reset in the middle of a window while mic_clk is high.
        mic_data = 1'b1;
        for (int k = 0; k < 3; k++) wait_fall(cyc);
        repeat (2) @(negedge clock);
        check("t6_pre_mic_clk", 32'(mic_clk), 32'd1);
        reset = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check("t6_mic_clk", 32'(mic_clk), 32'd0);
        check("t6_rd_data", rd_data, 32'h0000_0000);
        check("t6_count", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        run_window(7'h7F, 1'b1, 1'b0, 1'b0);
        check("t6_first", rd_data, 32'h8000_0007);
        check_state("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
